// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry, coordinate/colour widths and FSM states shared by the box drawer.
// The CLEAR state exists only when VGA_BOX_CLEAR_EN is defined.
package vga_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;
`ifdef VGA_BOX_CLEAR_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_FIN, ST_CLEAR} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_FIN} state_t;
`endif
endpackage

// File: rtl/raster_counter.sv
// raster_counter: loadable column/row offset walker; cx runs fastest, last flags the final pixel.
module raster_counter
    import vga_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_load,
    input  logic           i_en,
    input  logic [X_W-1:0] i_w,
    input  logic [Y_W-1:0] i_h,
    output logic [X_W-1:0] o_cx,
    output logic [Y_W-1:0] o_cy,
    output logic           o_last
);
    logic [X_W-1:0] r_w;
    logic [Y_W-1:0] r_h;
    logic           w_row_end;

    assign w_row_end = o_cx == r_w - 1'b1;
    assign o_last    = w_row_end && (o_cy == r_h - 1'b1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_cx <= '0;
            o_cy <= '0;
            r_w  <= '0;
            r_h  <= '0;
        end else if (i_load) begin
            o_cx <= '0;
            o_cy <= '0;
            r_w  <= i_w;
            r_h  <= i_h;
        end else if (i_en) begin
            o_cx <= w_row_end ? '0 : o_cx + 1'b1;
            o_cy <= w_row_end ? o_cy + 1'b1 : o_cy;
        end
    end
endmodule

// File: rtl/vga_box_drawer.sv
// vga_box_drawer: rasterises a clipped filled box, one pixel per clock, onto the VGA plot interface.
// Defining VGA_BOX_CLEAR_EN adds a full-screen clear walked with colour 0.
module vga_box_drawer #(
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    clear,
    input  logic [vga_pkg::X_W-1:0] x0,
    input  logic [vga_pkg::Y_W-1:0] y0,
    input  logic [vga_pkg::X_W-1:0] w,
    input  logic [vga_pkg::Y_W-1:0] h,
    input  logic [vga_pkg::C_W-1:0] colour_in,
    output logic [vga_pkg::X_W-1:0] x,
    output logic [vga_pkg::Y_W-1:0] y,
    output logic [vga_pkg::C_W-1:0] colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);
    import vga_pkg::*;

    state_t         r_state, w_next;
    logic [X_W-1:0] r_x0, w_cx, w_lim_w;
    logic [Y_W-1:0] r_y0, w_cy, w_lim_h;
    logic [C_W-1:0] r_col;
    logic [X_W:0]   w_px;
    logic [Y_W:0]   w_py;
    logic           w_clr, w_walk, w_accept, w_last, w_vis;
    logic           w_plot_d, w_busy_d, w_done_d;

`ifdef VGA_BOX_CLEAR_EN
    assign w_clr  = clear;
    assign w_walk = r_state == ST_DRAW || r_state == ST_CLEAR;
`else
    logic w_unused;
    assign w_unused = clear;
    assign w_clr    = 1'b0;
    assign w_walk   = r_state == ST_DRAW;
`endif

    assign w_accept = r_state == ST_IDLE && (start || w_clr);
    assign w_lim_w  = w_clr ? X_W'(SCREEN_W) : w;
    assign w_lim_h  = w_clr ? Y_W'(SCREEN_H) : h;

    raster_counter u_cnt (
        .i_clk  (CLOCK_50),
        .i_rst_n(resetn),
        .i_load (w_accept),
        .i_en   (w_walk),
        .i_w    (w_lim_w),
        .i_h    (w_lim_h),
        .o_cx   (w_cx),
        .o_cy   (w_cy),
        .o_last (w_last)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_x0  <= w_clr ? '0 : x0;
                r_y0  <= w_clr ? '0 : y0;
                r_col <= w_clr ? '0 : colour_in;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
`ifdef VGA_BOX_CLEAR_EN
                if (w_clr) w_next = ST_CLEAR;
                else
`endif
                if (start) w_next = (w == '0 || h == '0) ? ST_FIN : ST_DRAW;
            end
            ST_DRAW:  w_next = w_last ? ST_FIN : ST_DRAW;
`ifdef VGA_BOX_CLEAR_EN
            ST_CLEAR: w_next = w_last ? ST_FIN : ST_CLEAR;
`endif
            default:  w_next = ST_IDLE;
        endcase
    end

    // 9/8-bit sums so offsets past the screen edge clip instead of wrapping
    always_comb begin
        w_px     = {1'b0, r_x0} + {1'b0, w_cx};
        w_py     = {1'b0, r_y0} + {1'b0, w_cy};
        w_vis    = w_px < (X_W+1)'(SCREEN_W) && w_py < (Y_W+1)'(SCREEN_H);
        w_plot_d = w_walk && w_vis;
        w_busy_d = w_walk;
        w_done_d = r_state == ST_FIN;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            x      <= w_px[X_W-1:0];
            y      <= w_py[Y_W-1:0];
            colour <= r_col;
            plot   <= w_plot_d;
            busy   <= w_busy_d;
            done   <= w_done_d;
        end
    end
endmodule

// File: tb/tb_vga_box_drawer.sv
// tb_vga_box_drawer: directed vectors for vga_box_drawer with hand-computed pixel streams and timings.
// The clear scenario follows VGA_BOX_CLEAR_EN.
module tb_vga_box_drawer;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] x0 = '0;
    logic [6:0] y0 = '0;
    logic [7:0] w = '0;
    logic [6:0] h = '0;
    logic [2:0] colour_in = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int total = 0;
    int bad = 0;
    logic [17:0] pix[$];
    int np, td, nb, tf, acc;

    vga_box_drawer dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .start    (start),
        .clear    (clear),
        .x0       (x0),
        .y0       (y0),
        .w        (w),
        .h        (h),
        .colour_in(colour_in),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic setup(input logic [7:0] ax, input logic [6:0] ay, input logic [7:0] aw,
                         input logic [6:0] ah, input logic [2:0] ac);
        x0 = ax; y0 = ay; w = aw; h = ah; colour_in = ac; start = 1'b1;
    endtask

    // Accept edge, then scrambles the box inputs to prove they were latched.
    task automatic run(input int lim, input int poke, output int n_plot, output int t_done,
                       output int n_busy, output int t_first);
        n_plot = 0; t_done = 0; n_busy = 0; t_first = 0;
        pix.delete();
        tick();
        start = 1'b0; clear = 1'b0;
        x0 = 8'd0; y0 = 7'd0; w = 8'd1; h = 7'd1; colour_in = 3'd7;
        for (int k = 1; k <= lim; k++) begin
            tick();
            start = (k == poke);
            if (plot) begin
                n_plot++;
                pix.push_back({x, y, colour});
                if (t_first == 0) t_first = k;
            end
            if (busy) n_busy++;
            if (done) begin
                t_done = k;
                break;
            end
        end
        start = 1'b0;
        tick();
    endtask

    function automatic logic [17:0] px_at(input int i);
        return (i < pix.size()) ? pix[i] : 18'h3ffff;
    endfunction

    initial begin
        tick(); tick();
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_flags", {plot, busy, done}, 0);
        resetn = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acc += int'(plot) + int'(busy) + int'(done) + int'(x) + int'(y) + int'(colour);
        end
        chk("idle_quiet", acc, 0);

        setup(8'd10, 7'd20, 8'd3, 7'd2, 3'b100);
        run(100, 0, np, td, nb, tf);
        chk("a_plots", np, 6);
        chk("a_first", tf, 1);
        chk("a_done", td, 7);
        chk("a_busy", nb, 6);
        chk("a_p0", px_at(0), {8'd10, 7'd20, 3'd4});
        chk("a_p1", px_at(1), {8'd11, 7'd20, 3'd4});
        chk("a_p2", px_at(2), {8'd12, 7'd20, 3'd4});
        chk("a_p3", px_at(3), {8'd10, 7'd21, 3'd4});
        chk("a_p4", px_at(4), {8'd11, 7'd21, 3'd4});
        chk("a_p5", px_at(5), {8'd12, 7'd21, 3'd4});

        setup(8'd158, 7'd119, 8'd4, 7'd2, 3'd2);
        run(100, 0, np, td, nb, tf);
        chk("b_plots", np, 2);
        chk("b_done", td, 9);
        chk("b_busy", nb, 8);
        chk("b_p0", px_at(0), {8'd158, 7'd119, 3'd2});
        chk("b_p1", px_at(1), {8'd159, 7'd119, 3'd2});

        setup(8'd5, 7'd5, 8'd0, 7'd3, 3'd1);
        run(100, 0, np, td, nb, tf);
        chk("c_plots", np, 0);
        chk("c_done", td, 1);
        chk("c_busy", nb, 0);

        setup(8'd0, 7'd0, 8'd5, 7'd5, 3'd3);
        run(100, 3, np, td, nb, tf);
        chk("d_plots", np, 25);
        chk("d_done", td, 26);
        chk("d_last", px_at(24), {8'd4, 7'd4, 3'd3});
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            acc += int'(busy) + int'(done);
        end
        chk("d_no_requeue", acc, 0);

`ifdef VGA_BOX_CLEAR_EN
        setup(8'd30, 7'd30, 8'd2, 7'd2, 3'd6);
        clear = 1'b1;
        run(20000, 0, np, td, nb, tf);
        chk("clr_plots", np, 19200);
        chk("clr_done", td, 19201);
        chk("clr_first", px_at(0), {8'd0, 7'd0, 3'd0});
        chk("clr_last", px_at(19199), {8'd159, 7'd119, 3'd0});
        acc = 0;
        foreach (pix[i]) acc += (pix[i][2:0] != 3'd0) ? 1 : 0;
        chk("clr_colour", acc, 0);
`else
        clear = 1'b1;
        tick();
        clear = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            acc += int'(busy) + int'(done) + int'(plot);
        end
        chk("clr_ignored", acc, 0);
`endif

        setup(8'd20, 7'd30, 8'd5, 7'd5, 3'd5);
        tick();
        start = 1'b0;
        np = 0;
        for (int k = 0; k < 50 && np < 4; k++) begin
            tick();
            if (plot) np++;
        end
        chk("r_reached4", np, 4);
        resetn = 1'b0;
        tick();
        chk("r_plot", plot, 0);
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        resetn = 1'b1;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            acc += int'(busy) + int'(done) + int'(plot);
        end
        chk("r_quiet", acc, 0);

        setup(8'd1, 7'd1, 8'd2, 7'd2, 3'd1);
        run(100, 0, np, td, nb, tf);
        chk("e_plots", np, 4);
        chk("e_done", td, 5);
        chk("e_p3", px_at(3), {8'd2, 7'd2, 3'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
